// File: rtl/jtkcpu_idx_ea.sv
// Indexed-addressing effective-address sequencer: fetches offset bytes, applies
// auto inc/dec to the index register, optionally follows one indirection.
module jtkcpu_idx_ea (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        start,
  input  logic [7:0]  postbyte,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] u,
  input  logic [15:0] s,
  input  logic [15:0] pc,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] bus_addr,
  output logic        bus_rd,
  input  logic [7:0]  bus_din,
  output logic        reg_we,
  output logic [1:0]  reg_sel,
  output logic [15:0] reg_wdata,
  output logic        pc_we,
  output logic [15:0] pc_out,
  output logic [15:0] ea,
  output logic        done,
  output logic        illegal,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, FETCH_HI, FETCH_LO, CALC, IND_HI, IND_LO, DONE
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  pb_q;
  logic [15:0] pc_q;
  logic [15:0] off_q;
  logic [15:0] ea_q;
  logic [7:0]  ind_hi_q;
  logic        fetched_q;
  logic        ill_q;

  logic [15:0] rval;
  logic [15:0] calc_ea;
  logic [15:0] calc_wdata;
  logic        calc_wb;
  logic        calc_ill;
  logic        ind_go;
  logic [1:0]  start_bytes;

  // Number of instruction-stream bytes a postbyte needs.
  function automatic logic [1:0] offset_bytes(input logic [7:0] p);
    offset_bytes = 2'd0;
    if (p[7]) begin
      case (p[3:0])
        4'b1000, 4'b1100: offset_bytes = 2'd1;
        4'b1001, 4'b1101: offset_bytes = 2'd2;
        4'b1111:          offset_bytes = p[4] ? 2'd2 : 2'd0;
        default:          offset_bytes = 2'd0;
      endcase
    end
  endfunction

  assign start_bytes = offset_bytes(postbyte);

  // Register values are read live in CALC; the caller keeps them stable.
  always_comb begin
    case (pb_q[6:5])
      2'd0:    rval = x;
      2'd1:    rval = y;
      2'd2:    rval = u;
      default: rval = s;
    endcase
    calc_ea    = rval;
    calc_wdata = rval;
    calc_wb    = 1'b0;
    calc_ill   = 1'b0;
    if (!pb_q[7]) begin
      calc_ea = rval + {{11{pb_q[4]}}, pb_q[4:0]};
    end else begin
      case (pb_q[3:0])
        4'b0000: begin calc_wdata = rval + 16'd1; calc_wb = 1'b1; end
        4'b0001: begin calc_wdata = rval + 16'd2; calc_wb = 1'b1; end
        4'b0010: begin calc_ea = rval - 16'd1; calc_wdata = rval - 16'd1; calc_wb = 1'b1; end
        4'b0011: begin calc_ea = rval - 16'd2; calc_wdata = rval - 16'd2; calc_wb = 1'b1; end
        4'b0100: calc_ea = rval;
        4'b0101: calc_ea = rval + {{8{b[7]}}, b};
        4'b0110: calc_ea = rval + {{8{a[7]}}, a};
        4'b1000: calc_ea = rval + {{8{off_q[7]}}, off_q[7:0]};
        4'b1001: calc_ea = rval + off_q;
        4'b1011: calc_ea = rval + {a, b};
        4'b1100: calc_ea = pc_q + {{8{off_q[7]}}, off_q[7:0]};
        4'b1101: calc_ea = pc_q + off_q;
        4'b1111: begin
          if (pb_q[4]) calc_ea = off_q;
          else         calc_ill = 1'b1;
        end
        default: calc_ill = 1'b1;
      endcase
    end
  end

  assign ind_go = pb_q[7] & pb_q[4] & ~calc_ill;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          case (start_bytes)
            2'd2:    state_nx = FETCH_HI;
            2'd1:    state_nx = FETCH_LO;
            default: state_nx = CALC;
          endcase
        end
      end
      FETCH_HI: state_nx = FETCH_LO;
      FETCH_LO: state_nx = CALC;
      CALC:     state_nx = ind_go ? IND_HI : DONE;
      IND_HI:   state_nx = IND_LO;
      IND_LO:   state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (cen) begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pb_q      <= 8'd0;
      pc_q      <= 16'd0;
      off_q     <= 16'd0;
      ea_q      <= 16'd0;
      ind_hi_q  <= 8'd0;
      fetched_q <= 1'b0;
      ill_q     <= 1'b0;
    end else if (cen) begin
      case (state)
        IDLE: begin
          if (start) begin
            pb_q      <= postbyte;
            pc_q      <= pc;
            off_q     <= 16'd0;
            fetched_q <= (start_bytes != 2'd0);
            ill_q     <= 1'b0;
          end
        end
        FETCH_HI: begin
          off_q[15:8] <= bus_din;
          pc_q        <= pc_q + 16'd1;
        end
        FETCH_LO: begin
          off_q[7:0] <= bus_din;
          pc_q       <= pc_q + 16'd1;
        end
        CALC: begin
          ea_q  <= calc_ea;
          ill_q <= calc_ill;
        end
        IND_HI: ind_hi_q <= bus_din;
        IND_LO: ea_q     <= {ind_hi_q, bus_din};
        default: ;
      endcase
    end
  end

  always_comb begin
    bus_rd   = 1'b0;
    bus_addr = 16'd0;
    case (state)
      FETCH_HI, FETCH_LO: begin bus_rd = 1'b1; bus_addr = pc_q; end
      IND_HI:             begin bus_rd = 1'b1; bus_addr = ea_q; end
      IND_LO:             begin bus_rd = 1'b1; bus_addr = ea_q + 16'd1; end
      default: ;
    endcase
  end

  assign reg_we    = (state == CALC) & calc_wb;
  assign reg_sel   = pb_q[6:5];
  assign reg_wdata = reg_we ? calc_wdata : 16'd0;
  assign done      = (state == DONE);
  assign pc_we     = done & fetched_q;
  assign pc_out    = pc_we ? pc_q : 16'd0;
  assign ea        = ea_q;
  assign illegal   = done & ill_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_jtkcpu_idx_ea.sv
// Bench for jtkcpu_idx_ea: directed vector table, hand sequences for start/reset
// corners, and randomized operations against an address-mode reference model.
module tb_jtkcpu_idx_ea;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  postbyte = 8'd0;
  logic [15:0] x = 0, y = 0, u = 0, s = 0, pc = 0;
  logic [7:0]  a = 0, b = 0;
  logic [15:0] bus_addr;
  logic        bus_rd;
  logic [7:0]  bus_din;
  logic        reg_we;
  logic [1:0]  reg_sel;
  logic [15:0] reg_wdata;
  logic        pc_we;
  logic [15:0] pc_out;
  logic [15:0] ea;
  logic        done;
  logic        illegal;
  logic        busy;

  logic [7:0]  mem [0:65535];
  assign bus_din = mem[bus_addr];

  jtkcpu_idx_ea dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .start(start), .postbyte(postbyte),
    .x(x), .y(y), .u(u), .s(s), .pc(pc), .a(a), .b(b),
    .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_din(bus_din),
    .reg_we(reg_we), .reg_sel(reg_sel), .reg_wdata(reg_wdata),
    .pc_we(pc_we), .pc_out(pc_out), .ea(ea), .done(done),
    .illegal(illegal), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] ea;
    logic        we;
    logic [1:0]  sel;
    logic [15:0] wd;
    logic        pcwe;
    logic [15:0] pcout;
    logic        ill;
    logic [3:0]  lat;
    logic [2:0]  rd;
  } exp_t;

  typedef struct packed {
    logic [7:0]  pb;
    logic [15:0] x, y, u, s, pc;
    logic [7:0]  a, b;
    exp_t        e;
  } vec_t;

  vec_t        tbl[$];
  logic [15:0] exp_q[$];
  int          n_vec = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  int          obs_rd, obs_we, obs_pcwe, obs_lat, obs_we_at;
  logic [15:0] obs_ea, obs_wd, obs_pcout;
  logic [1:0]  obs_sel;
  logic        obs_ill;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic fail(input string nm, input int act, input int expv);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, expv, $time);
  endtask

  function automatic exp_t mk(input logic [15:0] e_ea, input logic e_we, input logic [1:0] e_sel,
                              input logic [15:0] e_wd, input logic e_pcwe, input logic [15:0] e_pcout,
                              input logic e_ill, input logic [3:0] e_lat, input logic [2:0] e_rd);
    exp_t e;
    e.ea = e_ea; e.we = e_we; e.sel = e_sel; e.wd = e_wd; e.pcwe = e_pcwe;
    e.pcout = e_pcout; e.ill = e_ill; e.lat = e_lat; e.rd = e_rd;
    return e;
  endfunction

  // Reference model: addressing-mode semantics straight from the mode table.
  // Queues the expected read addresses in order as a side effect.
  function automatic exp_t model(input logic [7:0] p, input logic [15:0] rx, ry, ru, rs, rpc,
                                 input logic [7:0] ra, rb);
    exp_t        e;
    logic [15:0] regs [4];
    logic [15:0] r, ptr, n, n8, t;
    logic signed [4:0] o5;
    int          k;
    bit          ind;
    regs = '{rx, ry, ru, rs};
    r    = regs[p[6:5]];
    e    = '0;
    e.ea = r;
    e.sel = p[6:5];
    ptr  = rpc;
    k    = 0;
    ind  = 0;
    if (!p[7]) begin
      o5   = p[4:0];
      e.ea = r + 16'(int'(o5));
    end else begin
      ind = p[4];
      case (p[3:0])
        4'h8, 4'hC: k = 1;
        4'h9, 4'hD: k = 2;
        4'hF:       k = ind ? 2 : 0;
        default:    k = 0;
      endcase
      n = 16'd0;
      for (int i = 0; i < k; i++) begin
        n = {n[7:0], mem[ptr]};
        exp_q.push_back(ptr);
        ptr = ptr + 16'd1;
      end
      n8 = 16'(int'($signed(n[7:0])));
      case (p[3:0])
        4'h0: begin e.we = 1; e.wd = r + 16'd1; end
        4'h1: begin e.we = 1; e.wd = r + 16'd2; end
        4'h2: begin e.ea = r - 16'd1; e.we = 1; e.wd = r - 16'd1; end
        4'h3: begin e.ea = r - 16'd2; e.we = 1; e.wd = r - 16'd2; end
        4'h4: e.ea = r;
        4'h5: e.ea = r + 16'(int'($signed(rb)));
        4'h6: e.ea = r + 16'(int'($signed(ra)));
        4'h8: e.ea = r + n8;
        4'h9: e.ea = r + n;
        4'hB: e.ea = r + {ra, rb};
        4'hC: e.ea = ptr + n8;
        4'hD: e.ea = ptr + n;
        4'hF: begin if (ind) e.ea = n; else e.ill = 1; end
        default: e.ill = 1;
      endcase
      if (ind && !e.ill) begin
        t = e.ea + 16'd1;
        exp_q.push_back(e.ea);
        exp_q.push_back(t);
        e.ea = {mem[e.ea], mem[t]};
      end
    end
    e.pcwe  = (k > 0);
    e.pcout = e.pcwe ? ptr : 16'd0;
    e.lat   = 4'(2 + k + ((ind && !e.ill) ? 2 : 0));
    e.rd    = 3'(k + ((ind && !e.ill) ? 2 : 0));
    return e;
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input bit rand_cen);
    int  edges, iter;
    bit  fin;
    obs_rd = 0; obs_we = 0; obs_pcwe = 0; obs_lat = 0; obs_we_at = 0;
    obs_ea = 0; obs_wd = 0; obs_pcout = 0; obs_sel = 0; obs_ill = 0;
    @(negedge clk);
    start = 1'b1;
    cen   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    fin   = 0;
    iter  = 0;
    while (!fin && iter < 60) begin
      iter++;
      cen = rand_cen ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (cen) begin
        if (bus_rd) begin
          obs_rd++;
          if (exp_q.size() == 0) fail("rd_unexpected", 1, 0);
          else chk("rd_addr", bus_addr, exp_q.pop_front());
        end
        if (reg_we) begin
          obs_we++; obs_sel = reg_sel; obs_wd = reg_wdata; obs_we_at = edges;
        end
        if (pc_we) begin
          obs_pcwe++; obs_pcout = pc_out;
        end
        if (done) begin
          obs_ea = ea; obs_ill = illegal; obs_lat = edges; fin = 1;
        end
      end
      @(posedge clk);
      if (cen) edges++;
      @(negedge clk);
    end
    cen = 1'b1;
    if (!fin) fail("done_timeout", iter, 0);
    if (exp_q.size() != 0) begin
      fail("rd_missing", exp_q.size(), 0);
      exp_q.delete();
    end
    chk("idle_after_done", busy, 1'b0);
  endtask

  task automatic compare(input exp_t e);
    chk("ea", obs_ea, e.ea);
    chk("illegal", obs_ill, e.ill);
    chk("latency", obs_lat, e.lat);
    chk("reads", obs_rd, e.rd);
    chk("reg_we_count", obs_we, e.we);
    if (e.we) begin
      chk("reg_sel", obs_sel, e.sel);
      chk("reg_wdata", obs_wd, e.wd);
      chk("reg_we_cycle", obs_we_at, 1);
    end
    chk("pc_we_count", obs_pcwe, e.pcwe);
    if (e.pcwe) chk("pc_out", obs_pcout, e.pcout);
  endtask

  task automatic apply(input vec_t v);
    exp_t m;
    postbyte = v.pb; x = v.x; y = v.y; u = v.u; s = v.s; pc = v.pc; a = v.a; b = v.b;
    m = model(v.pb, v.x, v.y, v.u, v.s, v.pc, v.a, v.b);
    run_op(1'b0);
    compare(v.e);
    n_vec++;
  endtask

  task automatic add(input logic [7:0] p, input logic [15:0] vx, vy, vu, vs, vpc,
                     input logic [7:0] va, vb, input exp_t e);
    vec_t v;
    v.pb = p; v.x = vx; v.y = vy; v.u = vu; v.s = vs; v.pc = vpc; v.a = va; v.b = vb; v.e = e;
    tbl.push_back(v);
  endtask

  function automatic logic [71:0] all_outs();
    return {bus_addr, bus_rd, reg_we, reg_sel, reg_wdata, pc_we, pc_out, ea, done, illegal, busy};
  endfunction

  // ---------------- test ----------------
  initial begin
    int   seen;
    exp_t m;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h2000] = 8'h80;
    mem[16'h3000] = 8'h40; mem[16'h3001] = 8'h10;
    mem[16'h4010] = 8'h12; mem[16'h4011] = 8'h34;
    mem[16'h5000] = 8'hF0; mem[16'h5001] = 8'h00;
    mem[16'h6000] = 8'h01; mem[16'h6001] = 8'h00;
    mem[16'h1100] = 8'hAB; mem[16'h1101] = 8'hCD;
    mem[16'hFFFF] = 8'h56; mem[16'h0000] = 8'h78;

    //   pb     x        y        u        s        pc       a      b          ea      we sel wd      pcwe pcout   ill lat rd
    add(8'h1F, 16'h1000, 16'h0, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0, mk(16'h0FFF, 0, 0, 16'h0, 0, 16'h0, 0, 2, 0));
    add(8'h81, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0, mk(16'hFFFF, 1, 0, 16'h0001, 0, 16'h0, 0, 2, 0));
    add(8'hAC, 16'h0, 16'h7777, 16'h0, 16'h0, 16'h2000, 8'h0, 8'h0, mk(16'h1F81, 0, 1, 16'h0, 1, 16'h2001, 0, 3, 1));
    add(8'h9F, 16'h0, 16'h0, 16'h0, 16'h0, 16'h3000, 8'h0, 8'h0, mk(16'h1234, 0, 0, 16'h0, 1, 16'h3002, 0, 6, 4));
    add(8'h87, 16'h5555, 16'h0, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0, mk(16'h5555, 0, 0, 16'h0, 0, 16'h0, 1, 2, 0));
    add(8'h83, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0, mk(16'hFFFF, 1, 0, 16'hFFFF, 0, 16'h0, 0, 2, 0));
    add(8'hC2, 16'h0, 16'h0, 16'h0000, 16'h0, 16'h0, 8'h0, 8'h0, mk(16'hFFFF, 1, 2, 16'hFFFF, 0, 16'h0, 0, 2, 0));
    add(8'hEB, 16'h0, 16'h0, 16'h0, 16'hFFF0, 16'h0, 8'h00, 8'h20, mk(16'h0010, 0, 3, 16'h0, 0, 16'h0, 0, 2, 0));
    add(8'h89, 16'h1000, 16'h0, 16'h0, 16'h0, 16'h5000, 8'h0, 8'h0, mk(16'h0000, 0, 0, 16'h0, 1, 16'h5002, 0, 4, 2));
    add(8'h0F, 16'hFFF8, 16'h0, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0, mk(16'h0007, 0, 0, 16'h0, 0, 16'h0, 0, 2, 0));
    add(8'hA5, 16'h0, 16'h0100, 16'h0, 16'h0, 16'h0, 8'h0, 8'h80, mk(16'h0080, 0, 1, 16'h0, 0, 16'h0, 0, 2, 0));
    add(8'hB9, 16'h0, 16'h1000, 16'h0, 16'h0, 16'h6000, 8'h0, 8'h0, mk(16'hABCD, 0, 1, 16'h0, 1, 16'h6002, 0, 6, 4));
    add(8'h94, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0, mk(16'h5678, 0, 0, 16'h0, 0, 16'h0, 0, 4, 2));

    // Reset state, held and after release
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 72'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_outputs", all_outs(), 72'd0);

    foreach (tbl[i]) apply(tbl[i]);

    // start held high across done: ignored in DONE, accepted once back in IDLE
    postbyte = 8'h84; x = 16'h4242;
    @(negedge clk); start = 1'b1; cen = 1'b1;
    @(posedge clk); @(negedge clk); chk("held_busy1", busy, 1'b1);
    @(posedge clk); @(negedge clk); chk("held_done1", done, 1'b1); chk("held_ea", ea, 16'h4242);
    @(posedge clk); @(negedge clk); chk("held_idle", busy, 1'b0); chk("held_nodone", done, 1'b0);
    @(posedge clk); @(negedge clk); chk("held_reaccept", busy, 1'b1); start = 1'b0;
    @(posedge clk); @(negedge clk); chk("held_done2", done, 1'b1);
    @(posedge clk); @(negedge clk);
    n_vec++;

    // Reset asserted in IND_HI of [n16,Y]
    postbyte = 8'hB9; y = 16'h1000; pc = 16'h6000;
    start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("abort_in_ind_hi_rd", bus_rd, 1'b1);
    chk("abort_in_ind_hi_addr", bus_addr, 16'h1100);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", all_outs(), 72'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(posedge clk); @(negedge clk);
      if (done || pc_we || reg_we || bus_rd) seen++;
    end
    chk("abort_quiet", seen, 0);
    m = model(8'hB9, x, 16'h1000, u, s, 16'h6000, a, b);
    run_op(1'b0);
    compare(m);
    n_vec++;

    // Randomized operations with random cen gaps
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 250; i++) begin
      postbyte = 8'($urandom);
      x = 16'($urandom); y = 16'($urandom); u = 16'($urandom); s = 16'($urandom);
      pc = 16'($urandom); a = 8'($urandom); b = 8'($urandom);
      if ($urandom_range(0, 7) == 0) x = 16'hFFFF;
      m = model(postbyte, x, y, u, s, pc, a, b);
      run_op(1'b1);
      compare(m);
      n_vec++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jtkcpu_idx_ea.md
# jtkcpu_idx_ea

Indexed-addressing effective-address sequencer for the KONAMI-2 CPU core. It runs after the opcode fetch. It takes the indexed-mode postbyte and the live register file values, fetches 0–2 offset bytes from the instruction stream, and updates the index register for auto-increment/decrement modes. It optionally performs the 16-bit indirect read, then hands the final effective address (EA) and the advanced PC back to the execution sequencer.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cen  in  1  clock enable; all state advances only when high
- start  in  1  begin decode; sampled only in IDLE with cen high
- postbyte  in  8  indexed postbyte, held by caller during the operation
- x, y, u, s  in  16 each  index registers
- pc  in  16  PC pointing at the first byte after the postbyte
- a, b  in  8 each  accumulators (D = {a,b})
- bus_addr  out  16  read address
- bus_rd  out  1  read strobe
- bus_din  in  8  read data, valid in the same cen cycle as bus_rd
- reg_we  out  1  index write strobe (one cen cycle)
- reg_sel  out  2  0=X, 1=Y, 2=U, 3=S
- reg_wdata  out  16  updated index value
- pc_we  out  1  PC write strobe (one cen cycle)
- pc_out  out  16  advanced PC
- ea  out  16  effective address, valid while done is high
- done  out  1  operation complete (one cen cycle)
- illegal  out  1  reserved mode encountered, qualified by done
- busy  out  1  high in every state except IDLE

## Operation
Decoding:
- postbyte[7]=0: 5-bit signed offset in [4:0]; register in [6:5]; no indirection.
- postbyte[7]=1: mode = [3:0]; indirect = [4]; register = [6:5].

Modes (R = selected register):
- 0000 ,R+ : EA=R; write R+1
- 0001 ,R++ : EA=R; write R+2
- 0010 ,-R : EA=R-1; write R-1
- 0011 ,--R : EA=R-2; write R-2
- 0100 ,R : EA=R
- 0101 B,R : EA=R+sext(B)
- 0110 A,R : EA=R+sext(A)
- 1000 n8,R : fetch 1 byte; EA=R+sext(n8)
- 1001 n16,R : fetch hi, then lo; EA=R+n16
- 1011 D,R : EA=R+D
- 1100 n8,PCR : fetch 1 byte; EA=PC'+sext(n8); PC' = PC after the fetch
- 1101 n16,PCR : fetch 2 bytes; EA=PC'+n16
- 1111 with indirect=1 : fetch n16; EA=n16
- 0111, 1010, 1110, and 1111 with indirect=0 : EA=R; illegal=1; no register or PC write

Arithmetic and fetch rules:
- All arithmetic is 16-bit modulo 2^16; wrap-around is silent (FFFF+1=0000; 0000-2=FFFE).
- If indirect=1, the sequencer reads the 16-bit big-endian word at the computed EA (EA, then EA+1, both wrapping) and uses it as the final EA.

State machine (transitions on cen):
- IDLE → FETCH_HI/FETCH_LO (if offset bytes are needed) or CALC
- FETCH_HI → FETCH_LO
- FETCH_LO → CALC
- CALC → IND_HI (if indirect and mode is legal) or DONE
- IND_HI → IND_LO → DONE
- DONE → IDLE

State actions:
- Fetch states drive bus_addr from the internal PC copy (latched at start) with bus_rd=1, capture bus_din, and increment the PC copy.
- CALC latches EA and pulses reg_we for modes 0000–0011.
- DONE pulses done; it also pulses pc_we with pc_out=PC copy when at least one offset byte was fetched.

## Timing
- Reset values: bus_addr=0, bus_rd=0, reg_we=0, reg_sel=0, reg_wdata=0, pc_we=0, pc_out=0, ea=0, done=0, illegal=0, busy=0; state=IDLE.
- Latency from the cen edge that accepts start to the cen cycle with done high: 2 + offset bytes + (2 if indirect).
  - ,R : 2
  - n16,R : 4
  - [n16,R] : 6
  - [n16] : 6
- bus_rd is high for exactly one cen cycle per byte. The register write precedes any indirect read.
- start while busy is ignored. start may be asserted in the same cen cycle that done is high; it is accepted only after the return to IDLE.
- With cen low, all state and outputs hold; strobes stay asserted but count only on cen cycles.
- rst_n low at any point aborts immediately to IDLE with all outputs at their reset values. No partial register or PC write completes.

## Test plan
- Postbyte 0x1F (5-bit −1, X), x=0x1000 → done 2 cycles after start; ea=0x0FFF; no reg_we, no pc_we.
- Postbyte 0x81 (,X++), x=0xFFFF → ea=0xFFFF; reg_we with reg_sel=0, reg_wdata=0x0001.
- Postbyte 0xAC (n8,PCR, Y field), pc=0x2000, byte 0x80 at 0x2000 → ea=0x1F81; pc_we with pc_out=0x2001; latency 3.
- Postbyte 0x9F ([n16]), pc=0x3000, mem[0x3000..3001]=0x40,0x10, mem[0x4010..4011]=0x12,0x34 → ea=0x1234; pc_out=0x3002; latency 6; bus_rd for 4 cycles.
- Postbyte 0x87 (reserved mode 0111) → done with illegal=1; ea=x; no reg_we, no pc_we.
- Postbyte 0xB9 ([n16,Y]): deassert rst_n during IND_HI → all outputs 0 at once; no done; the next start after release runs normally.
